// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter in front of one shared registered AND unit.
// One operation in flight; a new grant may coincide with the consumption of the last result.
module and_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_c,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy,
    output logic [CNTW-1:0]     op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    rsp_c_q, rsp_c_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];

    logic            can_accept;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [IDW:0]    scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*W +: W];
            assign b_arr[gi] = req_b[gi*W +: W];
        end
    endgenerate

    // Priority search starting at ptr; one extra bit lets ptr+k exceed NREQ before the explicit wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_c_d    = rsp_c_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        req_ready  = '0;
        can_accept = (state_q == IDLE) || rsp_ready;

        if (state_q == RESP && rsp_ready && op_count_q != {CNTW{1'b1}}) begin
            op_count_d = op_count_q + CNTW'(1);
        end

        if (can_accept && grant_found && !rst) begin
            req_ready[grant_id] = 1'b1;
            rsp_c_d  = a_arr[grant_id] & b_arr[grant_id];
            rsp_id_d = grant_id;
            ptr_d    = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
            state_d  = RESP;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rsp_c_q    <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_c_q    <= rsp_c_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q == RESP);
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter; a second instance with a 4-bit counter shares all inputs to check saturation.
module tb_and_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_c;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
    logic [CNTW-1:0]     op_count;

    logic [NREQ-1:0]     s_req_ready;
    logic                s_rsp_valid;
    logic [W-1:0]        s_rsp_c;
    logic [IDW-1:0]      s_rsp_id;
    logic                s_busy;
    logic [3:0]          s_op_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    and_unit_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    and_unit_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(4)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(s_rsp_c), .rsp_id(s_rsp_id), .busy(s_busy), .op_count(s_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt"}, 32'(op_count), 32'(cnt));
        check({tag, "_sat"}, 32'(s_op_count), 32'((cnt > 15) ? 15 : cnt));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset: requests present but nothing granted
        #2 check("rst_ready0", 32'(req_ready), 32'h0);
        tick();
        check("rst_ready1", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_c", 32'(rsp_c), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_valid", 32'(rsp_valid), 32'h0);
            check("idle_ready", 32'(req_ready), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
            check_counts("idle");
            tick();
        end

        // Single request from 2
        req_valid = 4'b0100;
        req_a[2*W +: W] = 8'hF0;
        req_b[2*W +: W] = 8'h3C;
        rsp_ready = 1'b1;
        #1 check("single_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_c", 32'(rsp_c), 32'h30);
        check("single_id", 32'(rsp_id), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        check("single_noready", 32'(req_ready), 32'h0);
        tick();
        cnt = 1;
        check("single_idle", 32'(rsp_valid), 32'h0);
        check_counts("single");

        // Round robin from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 8'hFF;
            req_b[i*W +: W] = 8'(i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NREQ;
            #1 check("rr_grant", 32'(req_ready), 32'(1 << g));
            tick();
            if (k > 0) cnt++;
            check("rr_id", 32'(rsp_id), 32'(g));
            check("rr_c", 32'(rsp_c), 32'(g));
        end
        req_valid = '0;
        tick();
        cnt++;
        check("rr_idle", 32'(rsp_valid), 32'h0);
        check_counts("rr");

        // Backpressure: ptr=1, grant requester 1 then stall
        req_a[1*W +: W] = 8'hAA;
        req_b[1*W +: W] = 8'h0F;
        req_valid = 4'b0010;
        #1 check("bp_grant", 32'(req_ready), 32'h2);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready0", 32'(req_ready), 32'h0);
            check("bp_c", 32'(rsp_c), 32'h0A);
            check("bp_id", 32'(rsp_id), 32'h1);
            check("bp_valid", 32'(rsp_valid), 32'h1);
            tick();
        end
        check_counts("bp_hold");
        req_a[3*W +: W] = 8'h55;
        req_b[3*W +: W] = 8'hFF;
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1 check("bp_release", 32'(req_ready), 32'h8);
        tick();
        cnt++;
        req_valid = '0;
        check("bp_id3", 32'(rsp_id), 32'h3);
        check("bp_c3", 32'(rsp_c), 32'h55);
        tick();
        cnt++;
        check("bp_idle", 32'(rsp_valid), 32'h0);
        check_counts("bp");

        // Reset while stalled in RESP: ptr would be 3 without the reset
        req_valid = 4'b0100;
        #1 check("mid_grant", 32'(req_ready), 32'h4);
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        rst = 1'b1;
        #1 check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        cnt = 0;
        check("mid_valid", 32'(rsp_valid), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check_counts("mid");
        rsp_ready = 1'b1;
        #1 check("mid_ptr0", 32'(req_ready), 32'h1);
        tick();
        check("mid_id0", 32'(rsp_id), 32'h0);
        req_valid = '0;
        tick();
        cnt = 1;
        check_counts("mid_done");

        // Saturation of the 4-bit counter instance
        req_valid = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k > 0) cnt++;
        end
        req_valid = '0;
        tick();
        cnt++;
        check("sat_main", 32'(op_count), 32'd21);
        check("sat_small", 32'(s_op_count), 32'd15);
        check_counts("sat");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
